// File: rtl/coin_key_encoder.sv
// Coin key front end: synchronises and debounces three coin keys, then issues
// one single-cycle 2-bit coin code per clean press, queuing simultaneous presses.
module coin_key_encoder #(
  parameter int DEB_CYCLES = 20,
  parameter int CNT_W      = 5
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [2:0] Key,
  output logic [1:0] Din,
  output logic       Valid,
  output logic [7:0] CoinCnt
);

  localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(DEB_CYCLES - 1);

  logic [2:0]       r_s1;
  logic [2:0]       r_s2;
  logic [2:0]       r_deb;
  logic [2:0]       r_debDly;
  logic [2:0]       r_pend;
  logic [CNT_W-1:0] r_cnt [3];

  logic [2:0] w_rise;
  logic [2:0] w_serve;
  logic [1:0] w_code;
  logic       w_any;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1 <= Key;
      r_s2 <= r_s1;
    end
  end

  // A level is accepted only after differing from deb for DEB_CYCLES cycles.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_deb <= '0;
      for (int i = 0; i < 3; i++) r_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (r_s2[i] == r_deb[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == LP_LAST) begin
          r_deb[i] <= r_s2[i];
          r_cnt[i] <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign w_rise = r_deb & ~r_debDly;
  assign w_any  = |r_pend;

  always_comb begin
    w_serve = 3'b000;
    w_code  = 2'b00;
    if (r_pend[0]) begin
      w_serve = 3'b001;
      w_code  = 2'b01;
    end else if (r_pend[1]) begin
      w_serve = 3'b010;
      w_code  = 2'b10;
    end else if (r_pend[2]) begin
      w_serve = 3'b100;
      w_code  = 2'b11;
    end
  end

  // A fresh rise on the index being served is kept, so the set term is ORed last.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_debDly <= '0;
      r_pend   <= '0;
      Din      <= 2'b00;
      Valid    <= 1'b0;
      CoinCnt  <= 8'd0;
    end else begin
      r_debDly <= r_deb;
      r_pend   <= (r_pend & ~w_serve) | w_rise;
      Din      <= w_code;
      Valid    <= w_any;
      CoinCnt  <= CoinCnt + {7'd0, w_any};
    end
  end

endmodule

// File: doc/coin_key_encoder.md
# coin_key_encoder

- Front-end stage of the vending-machine datapath.
- Takes three raw, bouncy coin keys from the board and synchronises and debounces each one.
- Turns every clean press into a single-cycle 2-bit coin code (01 = 1 unit, 10 = 2 units, 11 = 3 units) that drives the `Din` input of the downstream Mealy coin accumulator.
- Simultaneous presses are queued and issued one per cycle, so no coin is lost; an accepted-coin counter is provided for display.

## Interface
- `DEB_CYCLES`, default 20: consecutive stable cycles required to accept a level change. Must be ≥ 2.
- `CNT_W`, default 5: debounce counter width. Must satisfy 2^CNT_W > DEB_CYCLES.
- `Clk`  in  1: system clock. All state changes on the rising edge.
- `Reset`  in  1: asynchronous, active-low reset (0 = reset).
- `Key`  in  3: raw active-high coin keys. `Key[0]` = 1 unit, `Key[1]` = 2 units, `Key[2]` = 3 units. Asynchronous to `Clk`.
- `Din`  out  2: coin code to the accumulator. Registered. 00 when no coin is issued.
- `Valid`  out  1: high for exactly one cycle when `Din` carries a coin code. Registered.
- `CoinCnt`  out  8: count of issued coins. Registered. Wraps 255 → 0.

## Operation
- **Reset** (`Reset` = 0), asynchronous and immediate:
  - synchronisers, debounced levels, debounce counters and pending bits all go to 0;
  - `Din` = 00, `Valid` = 0, `CoinCnt` = 0.
- **Synchroniser:** two flops per key (`s1`, `s2`).
- **Debounce**, independently per key `i`:
  - If `s2[i]` equals `deb[i]`: `cnt[i]` ← 0.
  - Otherwise, if `cnt[i]` == DEB_CYCLES−1: `deb[i]` ← `s2[i]` and `cnt[i]` ← 0.
  - Otherwise: `cnt[i]` increments.
  - Net effect: a level is accepted only after it has differed from `deb[i]` for DEB_CYCLES consecutive cycles. Any shorter excursion is discarded.
- **Edge detect:** `rise[i]` = `deb[i]` updating from 0 to 1. Falling edges produce nothing.
- **Pending queue:**
  - 3-bit `pend` register. `rise[i]` sets `pend[i]`.
  - Each cycle with `pend` ≠ 0, serve the lowest set index `i` (priority Key0 > Key1 > Key2):
    - next `Din` = i+1, next `Valid` = 1, clear `pend[i]`;
    - if a new `rise[i]` arrives in the same cycle as `pend[i]` is served, the set wins (the new press is kept).
  - If `pend` = 0: next `Din` = 00, next `Valid` = 0.
- **CoinCnt:** increments by 1 in every cycle where the next `Valid` is 1, modulo 256.
- **Holding a key:** yields exactly one coin. Release plus a new debounced press yields the next coin.
- **Downstream:** the accumulator accepts a code every cycle, so there is no backpressure and back-to-back `Valid` pulses are legal.

## Timing
- Uncontended latency, counting edge 1 as the first rising edge at which `Key[i]` = 1 is sampled into `s1`:
  - `s2` valid after edge 2;
  - `deb[i]` = 1 after edge DEB_CYCLES+2;
  - `pend[i]` = 1 after edge DEB_CYCLES+3;
  - `Din`/`Valid` asserted after edge DEB_CYCLES+4, for one cycle.
- With DEB_CYCLES = 4: code appears after edge 8 and is gone after edge 9.
- Release latency is symmetric (DEB_CYCLES+2 edges to `deb` = 0), with no output.
- **Contention:**
  - k keys rising on the same edge produce k consecutive `Valid` cycles, in priority order, starting at the uncontended latency.
  - A pending coin waits at most 2 extra cycles.
- **Bounce:** a press of DEB_CYCLES−1 or fewer cycles is ignored. A single-cycle dropout during a held press resets `cnt`, not `deb`.
- **Reset mid-operation:** outstanding pending coins and partial debounce counts are discarded. After `Reset` returns to 1, a key that is still held is treated as a new press and issues a coin after DEB_CYCLES+4 edges.
- **Outputs** change only on rising `Clk` edges or on assertion of `Reset`. They are glitch-free into the Mealy block.

## Test plan
All scenarios use DEB_CYCLES = 4 unless stated.

1. **Reset:** hold `Reset` = 0 with `Key` = 111.
   - `Din` = 00, `Valid` = 0, `CoinCnt` = 0 throughout.
   - Release reset: single coins 01, 10, 11 after edges 8, 9, 10.
2. **Single press:** `Key[0]` high for 12 cycles, then low.
   - Exactly one `Valid` pulse with `Din` = 01 after edge 8. `CoinCnt` = 1.
   - Nothing on release.
3. **Bounce:**
   - `Key[1]` high 3 cycles, low 5 cycles, repeated 4 times: no `Valid`, `CoinCnt` stays 0.
   - Then `Key[1]` held 6 cycles: one `Din` = 10.
4. **Simultaneous:** `Key` 000 → 111 on one edge.
   - `Din` = 01, 10, 11 on three consecutive cycles, `Valid` high for exactly 3 cycles, `CoinCnt` = 3.
   - Feeding the Mealy model from reset, its `Dout` pulses on the 11 cycle (total 6 ≥ 4).
5. **Reset while pending:** `Key` → 111, assert `Reset` after edge 8 (only 01 issued).
   - 10 and 11 are never issued; `CoinCnt` = 0 after reset.
6. **Counter wrap:** DEB_CYCLES = 2, 256 clean `Key[2]` presses.
   - `CoinCnt` reads 255 after press 255, 0 after press 256.
   - Every pulse has `Din` = 11.
